// File: rtl/seg_pkg.sv
// Segment glyph constants for the seven-segment scanner.
// Glyphs are active-high {a,b,c,d,e,f,g}; display polarity is applied at the output registers.
package seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_0 = (7'd1 << SEG_A) | (7'd1 << SEG_B) | (7'd1 << SEG_C) |
                                 (7'd1 << SEG_D) | (7'd1 << SEG_E) | (7'd1 << SEG_F);
  localparam logic [6:0] SEG_1 = (7'd1 << SEG_B) | (7'd1 << SEG_C);
  localparam logic [6:0] SEG_2 = (7'd1 << SEG_A) | (7'd1 << SEG_B) | (7'd1 << SEG_D) |
                                 (7'd1 << SEG_E) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_3 = (7'd1 << SEG_A) | (7'd1 << SEG_B) | (7'd1 << SEG_C) |
                                 (7'd1 << SEG_D) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_4 = (7'd1 << SEG_B) | (7'd1 << SEG_C) | (7'd1 << SEG_F) |
                                 (7'd1 << SEG_G);
  localparam logic [6:0] SEG_5 = (7'd1 << SEG_A) | (7'd1 << SEG_C) | (7'd1 << SEG_D) |
                                 (7'd1 << SEG_F) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_6 = SEG_5 | (7'd1 << SEG_E);
  localparam logic [6:0] SEG_7 = (7'd1 << SEG_A) | (7'd1 << SEG_B) | (7'd1 << SEG_C);
  localparam logic [6:0] SEG_8 = SEG_0 | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_9 = SEG_3 | (7'd1 << SEG_F);
  localparam logic [6:0] SEG_HEX_A = SEG_7 | (7'd1 << SEG_E) | (7'd1 << SEG_F) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_HEX_B = (7'd1 << SEG_C) | (7'd1 << SEG_D) | (7'd1 << SEG_E) |
                                     (7'd1 << SEG_F) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_HEX_C = (7'd1 << SEG_A) | (7'd1 << SEG_D) | (7'd1 << SEG_E) |
                                     (7'd1 << SEG_F);
  localparam logic [6:0] SEG_HEX_D = (7'd1 << SEG_B) | (7'd1 << SEG_C) | (7'd1 << SEG_D) |
                                     (7'd1 << SEG_E) | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_HEX_E = SEG_HEX_C | (7'd1 << SEG_G);
  localparam logic [6:0] SEG_HEX_F = (7'd1 << SEG_A) | (7'd1 << SEG_E) | (7'd1 << SEG_F) |
                                     (7'd1 << SEG_G);

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_HEX_A;
      4'hB: glyph = SEG_HEX_B;
      4'hC: glyph = SEG_HEX_C;
      4'hD: glyph = SEG_HEX_D;
      4'hE: glyph = SEG_HEX_E;
      4'hF: glyph = SEG_HEX_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with hex decode, decimal points,
// blanking, leading-zero suppression and PWM brightness; inputs are sampled once per frame.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DIV_W      = 18,
  parameter int BRIGHT_W   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int   IDX_W = $clog2(N_DIGITS);
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_blank;
  logic                  snap_lz;
  logic [BRIGHT_W-1:0]   snap_bright;

  logic                  frame_start;
  logic                  suppressed;
  logic                  digit_on;
  logic [3:0]            cur_nibble;
  logic [N_DIGITS-1:0]   snap_nz;
  logic [N_DIGITS-1:0]   onehot;
  logic [6:0]            glyph;

  assign frame_start = (cnt == '0) && (idx == '0);
  assign onehot      = N_DIGITS'(1) << idx;

  always_comb begin
    cur_nibble = 4'h0;
    snap_nz    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      snap_nz[i] = |snap_digits[4*i +: 4];
      if (idx == IDX_W'(i)) cur_nibble = snap_digits[4*i +: 4];
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  assign suppressed = snap_lz && (idx != '0) && ((snap_nz >> idx) == '0);
  assign digit_on   = !snap_blank[idx] && !suppressed &&
                      (cnt[DIV_W-1 -: BRIGHT_W] <= snap_bright);

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .glyph  (glyph)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (frame_start) begin
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_blank  <= blank_mask;
        snap_lz     <= lz_en;
        snap_bright <= brightness;
      end
    end
  end

  // Pin registers; XOR with POL turns "lit" into the board's drive level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an         <= {N_DIGITS{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (digit_on) begin
        an  <= onehot ^ {N_DIGITS{POL}};
        seg <= glyph ^ {7{POL}};
        dp  <= snap_dp[idx] ^ POL;
      end else begin
        an  <= {N_DIGITS{POL}};
        seg <= {7{POL}};
        dp  <= POL;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 16-cycle slots, active-low pins):
// directed scenarios plus random input changes, checked every cycle against a frame-position model.
module tb_seven_seg_scanner;

  localparam int N_DIGITS = 4;
  localparam int DIV_W    = 4;
  localparam int BRIGHT_W = 2;
  localparam int SLOT     = 1 << DIV_W;
  localparam int FRAME    = SLOT * N_DIGITS;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;

  seven_seg_scanner #(
    .N_DIGITS   (N_DIGITS),
    .DIV_W      (DIV_W),
    .BRIGHT_W   (BRIGHT_W),
    .ACTIVE_LOW (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  // Lit segments per hex value, written as segment letters.
  string litTable [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] litMask(input string s);
    logic [6:0] m = 7'h00;
    for (int k = 0; k < s.len(); k++) begin
      int b = int'(s[k]) - 97;
      m = m | 7'(1 << (6 - b));
    end
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bm,
                               input logic lz, input logic [1:0] br);
    digits     = d;
    dp_in      = dpv;
    blank_mask = bm;
    lz_en      = lz;
    brightness = br;
  endtask

  // Reference model: position within the frame plus the values latched at frame start.
  int          pos = 0;
  logic [15:0] mDigits = 16'h0;
  logic [3:0]  mDp = 4'h0;
  logic [3:0]  mBlank = 4'h0;
  logic        mLz = 1'b0;
  logic [1:0]  mBright = 2'd0;
  logic [3:0]  expAn = 4'hF;
  logic [6:0]  expSeg = 7'h7F;
  logic        expDp = 1'b1;
  logic        expTick = 1'b0;
  int          mSlot, mPhase;
  bit          mOn;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos = 0;
      mDigits = 16'h0; mDp = 4'h0; mBlank = 4'h0; mLz = 1'b0; mBright = 2'd0;
      expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expTick = 1'b0;
    end else begin
      mSlot  = pos / SLOT;
      mPhase = pos % SLOT;
      mOn = !mBlank[mSlot] &&
            !(mLz && mSlot > 0 && (mDigits >> (4 * mSlot)) == 16'h0) &&
            ((mPhase * 4) / SLOT <= int'(mBright));
      if (mOn) begin
        expAn  = ~(4'b0001 << mSlot);
        expSeg = ~litMask(litTable[(mDigits >> (4 * mSlot)) & 16'hF]);
        expDp  = ~mDp[mSlot];
      end else begin
        expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1;
      end
      expTick = (pos == 0);
      if (pos == 0) begin
        mDigits = digits; mDp = dp_in; mBlank = blank_mask; mLz = lz_en; mBright = brightness;
      end
      pos = (pos + 1) % FRAME;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("frame_tick", 32'(frame_tick), 32'(expTick));
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    repeat (3) @(negedge clock);
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_tick", 32'(frame_tick), 32'h0);
    reset = 1'b1;

    // First frame shows 12AF from slot 0 onwards, two edges after release.
    repeat (2) @(negedge clock);
    checkOutput("d0_an", 32'(an), 32'b1110);
    checkOutput("d0_seg_F", 32'(seg), 32'b0111000);
    repeat (SLOT) @(negedge clock);
    checkOutput("d1_an", 32'(an), 32'b1101);
    checkOutput("d1_seg_A", 32'(seg), 32'b0001000);
    repeat (SLOT) @(negedge clock);
    checkOutput("d2_an", 32'(an), 32'b1011);
    checkOutput("d2_seg_2", 32'(seg), 32'b0010010);
    repeat (SLOT) @(negedge clock);
    checkOutput("d3_an", 32'(an), 32'b0111);
    checkOutput("d3_seg_1", 32'(seg), 32'b1001111);
    repeat (FRAME + 1 - 2 - 3 * SLOT) @(negedge clock);
    checkOutput("tick_frame2", 32'(frame_tick), 32'h1);
    repeat (FRAME) @(negedge clock);

    applyStimulus(16'h0045, 4'h0, 4'h0, 1'b1, 2'd3);
    repeat (2 * FRAME) @(negedge clock);
    applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
    repeat (2 * FRAME) @(negedge clock);
    applyStimulus(16'h8F3C, 4'h0, 4'h0, 1'b0, 2'd1);
    repeat (2 * FRAME) @(negedge clock);
    applyStimulus(16'h9B7E, 4'b0100, 4'b0001, 1'b0, 2'd3);
    repeat (2 * FRAME) @(negedge clock);

    // Mid-frame change at frame cycle 20 must not tear the current frame.
    for (int w = 0; w < FRAME && pos != 20; w++) @(negedge clock);
    checkOutput("align_mid", 32'(pos), 32'd20);
    applyStimulus(16'h5D60, 4'b1010, 4'h0, 1'b0, 2'd2);
    repeat (2 * FRAME) @(negedge clock);

    // Asynchronous reset inside slot 2.
    applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    for (int w = 0; w < FRAME && pos != 2 * SLOT + 5; w++) @(negedge clock);
    checkOutput("align_rst", 32'(pos), 32'(2 * SLOT + 5));
    #2 reset = 1'b0;
    #1;
    checkOutput("async_an", 32'(an), 32'hF);
    checkOutput("async_seg", 32'(seg), 32'h7F);
    checkOutput("async_dp", 32'(dp), 32'h1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("restart_an", 32'(an), 32'b1110);
    checkOutput("restart_seg", 32'(seg), 32'b0111000);

    // Random inputs changing at arbitrary points in the frame.
    for (int c = 0; c < 24 * FRAME; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 29) == 0) begin
        applyStimulus(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                      1'($urandom), 2'($urandom));
        if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
